control_stage_buffer: RTL and testbench
=======================================

# control_stage_buffer

Receiving end of the 32-bit pipeline control word: it accepts the control word produced by the decode stage and delivers it to the execute stage. It holds up to two words in a ready/valid skid buffer, so decode is not stalled combinationally by execute back-pressure. It also supports a synchronous pipeline flush and keeps accepted-word and flushed-word counters for the verification monitor.

## Interface
Parameters:
- WIDTH, 32, control word width in bits.
- CNT_W, 16, width of the statistic counters.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  decode presents a control word.
- in_ready  output  1  buffer can accept the word this cycle.
- in_control  input  WIDTH  control word from decode.
- flush  input  1  discard all buffered words; has priority over push and pop.
- out_valid  output  1  head word is valid.
- out_ready  input  1  execute consumes the head word.
- out_control  output  WIDTH  head control word; all-zero when out_valid=0.
- accept_count  output  CNT_W  number of words accepted; wraps.
- drop_count  output  CNT_W  number of words discarded by flush; saturates.

## Operation
- Storage is two WIDTH-bit entries, head and tail, with registered state EMPTY, ONE or FULL.
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- in_ready = !rst && !flush && (state != FULL). It is combinational from registered state and the rst/flush inputs only. It never depends on out_ready.
- out_valid = (state != EMPTY), driven directly from the register.
- out_control = head when out_valid=1, otherwise 0.
- Transitions when flush=0:
  - EMPTY: push → ONE, head ← in_control.
  - ONE, push only: → FULL, tail ← in_control.
  - ONE, pop only: → EMPTY.
  - ONE, push and pop: stays ONE, head ← in_control.
  - FULL, pop: → ONE, head ← tail. A push cannot occur in FULL because in_ready=0.
  - No push and no pop: state and data hold.
- Flush in any state:
  - Next state is EMPTY.
  - A pop in the same cycle is ignored and not counted as consumed.
  - The in_control word in the flush cycle is not accepted, because in_ready=0.
  - drop_count increases by the number of entries held: 0, 1 or 2. It saturates at 2^CNT_W−1 and never wraps.
- accept_count increments by 1 on every push and wraps modulo 2^CNT_W.
- Word order is strict FIFO. No word is duplicated, and none is lost except by flush.
- Data registers need no reset. Only the state and both counters are reset.

## Timing
- Reset (rst=1 at a clock edge):
  - Next state is EMPTY; accept_count=0; drop_count=0.
  - Resulting outputs: out_valid=0, out_control=0.
  - in_ready=0 in every cycle that rst=1, and 1 in the first cycle after rst drops.
- Reset mid-operation: buffered words are discarded without incrementing drop_count.
- Latency: a word pushed in cycle N appears at out_control with out_valid=1 in cycle N+1, when the buffer was EMPTY or was ONE with a pop in cycle N.
- Throughput: with out_ready held at 1, one word per cycle with no bubbles. The state stays in ONE.
- Back-pressure: with out_ready=0, the buffer accepts at most two words. in_ready falls in the cycle after the second push.
- Flush: the first cycle after the flush edge has out_valid=0. A new push is possible in that same cycle.

## Test plan
- Reset then stream: rst=1 for 2 cycles, then push 0x00000001..0x00000008 on consecutive cycles with out_ready=1. Required: in_ready=0 during reset; each word appears one cycle after its push, in order; accept_count=8; drop_count=0.
- Back-pressure fill: out_ready=0, push 0xA5A5A5A5 then 0x5A5A5A5A. Required: FULL after 2 cycles; in_ready=0; out_control holds 0xA5A5A5A5. Then out_ready=1 for 2 cycles: outputs 0xA5A5A5A5 then 0x5A5A5A5A, and in_ready returns to 1 after the first pop.
- Flush while FULL, with in_valid=1, in_control=0xDEADBEEF and out_ready=1 in the flush cycle. Required: next cycle out_valid=0, out_control=0, drop_count +2; 0xDEADBEEF is not accepted; accept_count is unchanged.
- Simultaneous push and pop in ONE: head=0x11, push 0x22, out_ready=1. Required: the 0x11 handshake completes; next cycle the state is ONE with out_control=0x22.
- Counter bounds, CNT_W=4: accept 17 words, then 16 flushes while ONE. Required: accept_count wraps to 1; drop_count saturates at 15.
- Reset mid-operation: with the buffer FULL, assert rst for 1 cycle. Required: next cycle out_valid=0, accept_count=0, drop_count=0.

Source files
------------

// File: rtl/control_stage_buffer_if.sv
// Handshake and status bundle between decode, the control stage buffer and execute.
// The slave modport is the buffer side; the master modport is the decode/execute side.
interface control_stage_buffer_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_control;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_control;
  logic [CNT_W-1:0] accept_count;
  logic [CNT_W-1:0] drop_count;

  modport slave (
    input  in_valid, in_control, flush, out_ready,
    output in_ready, out_valid, out_control, accept_count, drop_count
  );

  modport master (
    output in_valid, in_control, flush, out_ready,
    input  in_ready, out_valid, out_control, accept_count, drop_count
  );
endinterface

// File: rtl/control_stage_buffer.sv
// Two-entry ready/valid skid buffer for the pipeline control word, with
// synchronous flush plus accepted-word (wrapping) and flushed-word
// (saturating) counters.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | no word held, out_valid low
// ST_ONE   | head holds the only word
// ST_FULL  | head is oldest, tail is next; in_ready low
module control_stage_buffer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  control_stage_buffer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [CNT_W-1:0] r_accept;
  logic [CNT_W-1:0] r_drop;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_load_head_in;
  logic             w_load_head_tail;
  logic             w_load_tail;
  logic [1:0]       w_held;
  logic [CNT_W:0]   w_drop_sum;

  // in_ready looks only at registered state and rst/flush, never at out_ready.
  assign w_in_ready  = !rst && !bus.flush && (r_state != ST_FULL);
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_push      = bus.in_valid && w_in_ready;
  // A pop coinciding with a flush is discarded, not consumed.
  assign w_pop       = w_out_valid && bus.out_ready && !bus.flush;

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_control  = w_out_valid ? r_head : '0;
  assign bus.accept_count = r_accept;
  assign bus.drop_count   = r_drop;

  // Extra bit catches overflow so the drop counter can clamp instead of wrapping.
  assign w_drop_sum = {1'b0, r_drop} + {{(CNT_W-1){1'b0}}, w_held};

  // Next-state and data-move decode.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_head_in   = 1'b0;
    w_load_head_tail = 1'b0;
    w_load_tail      = 1'b0;
    w_held           = 2'd0;
    case (r_state)
      ST_EMPTY: begin
        w_held = 2'd0;
        if (w_push) begin
          w_state_nxt    = ST_ONE;
          w_load_head_in = 1'b1;
        end
      end
      ST_ONE: begin
        w_held = 2'd1;
        if (w_push && w_pop) begin
          w_load_head_in = 1'b1;
        end else if (w_push) begin
          w_state_nxt = ST_FULL;
          w_load_tail = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        w_held = 2'd2;
        if (w_pop) begin
          w_state_nxt      = ST_ONE;
          w_load_head_tail = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
    if (bus.flush) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Data entries carry no reset; validity is tracked by the state alone.
  always_ff @(posedge clk) begin
    if (w_load_head_in) begin
      r_head <= bus.in_control;
    end else if (w_load_head_tail) begin
      r_head <= r_tail;
    end
    if (w_load_tail) begin
      r_tail <= bus.in_control;
    end
  end

  // Statistic counters: accepted words wrap, flushed words saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_accept <= '0;
      r_drop   <= '0;
    end else begin
      if (w_push) begin
        r_accept <= r_accept + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (bus.flush) begin
        r_drop <= w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_control_stage_buffer.sv
// Bench for control_stage_buffer: a default-width instance and a CNT_W=4
// instance share one stimulus stream. A directed vector table checks the
// documented scenarios, and a queue-based reference model checks every
// cycle of both instances.
module tb_control_stage_buffer;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  logic             tb_in_valid;
  logic [WIDTH-1:0] tb_in_control;
  logic             tb_flush;
  logic             tb_out_ready;

  int errs;
  int checks;

  control_stage_buffer_if #(.WIDTH(WIDTH), .CNT_W(16)) if16 ();
  control_stage_buffer_if #(.WIDTH(WIDTH), .CNT_W(4))  if4 ();

  assign if16.in_valid   = tb_in_valid;
  assign if16.in_control = tb_in_control;
  assign if16.flush      = tb_flush;
  assign if16.out_ready  = tb_out_ready;
  assign if4.in_valid    = tb_in_valid;
  assign if4.in_control  = tb_in_control;
  assign if4.flush       = tb_flush;
  assign if4.out_ready   = tb_out_ready;

  control_stage_buffer #(.WIDTH(WIDTH), .CNT_W(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (if16.slave)
  );

  control_stage_buffer #(.WIDTH(WIDTH), .CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (scoreboard) ----------------
  logic [WIDTH-1:0] sb_q[$];
  int  m_accept;
  int  m_drop;
  bit  mon_en;

  function automatic logic [31:0] sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Compare every cycle at the falling edge, then advance the model to
  // what the coming rising edge must do.
  always @(negedge clk) begin
    if (mon_en) begin
      logic exp_ir;
      logic [31:0] exp_oc;
      exp_ir = !rst && !tb_flush && (sb_q.size() < 2);
      exp_oc = (sb_q.size() != 0) ? sb_q[0] : 32'h0;
      chk("sb_in_ready16", {31'b0, if16.in_ready}, {31'b0, exp_ir});
      chk("sb_in_ready4",  {31'b0, if4.in_ready},  {31'b0, exp_ir});
      chk("sb_out_valid16", {31'b0, if16.out_valid}, {31'b0, sb_q.size() != 0});
      chk("sb_out_valid4",  {31'b0, if4.out_valid},  {31'b0, sb_q.size() != 0});
      chk("sb_out_control16", if16.out_control, exp_oc);
      chk("sb_out_control4",  if4.out_control,  exp_oc);
      chk("sb_accept16", {16'b0, if16.accept_count}, m_accept & 32'hFFFF);
      chk("sb_accept4",  {28'b0, if4.accept_count},  m_accept & 32'hF);
      chk("sb_drop16", {16'b0, if16.drop_count}, sat(m_drop, 65535));
      chk("sb_drop4",  {28'b0, if4.drop_count},  sat(m_drop, 15));
      if (rst) begin
        sb_q.delete();
        m_accept = 0;
        m_drop   = 0;
      end else if (tb_flush) begin
        m_drop += sb_q.size();
        sb_q.delete();
      end else begin
        if (sb_q.size() != 0 && tb_out_ready) void'(sb_q.pop_front());
        if (tb_in_valid && exp_ir) begin
          sb_q.push_back(tb_in_control);
          m_accept++;
        end
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] din;
    logic        fl;
    logic        ordy;
    logic        e_ir;    // in_ready before the edge
    logic        e_ov;    // after the edge
    logic [31:0] e_oc;
    int          e_acc;   // unwrapped accept total
    int          e_drop;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] d,
                              input logic fl, input logic ordy, input logic e_ir,
                              input logic e_ov, input logic [31:0] e_oc,
                              input int e_acc, input int e_drop);
    vec_t v;
    v.rst = r; v.iv = iv; v.din = d; v.fl = fl; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_oc = e_oc; v.e_acc = e_acc; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errs = 0;
    checks = 0;
    mon_en = 1'b0;
    m_accept = 0;
    m_drop = 0;
    rst = 1'b1;
    tb_in_valid = 1'b0;
    tb_in_control = '0;
    tb_flush = 1'b0;
    tb_out_ready = 1'b0;

    // reset for two cycles
    vt.push_back(mk(1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0));
    vt.push_back(mk(1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0));
    // stream 1..8 with out_ready=1: each word visible one cycle after its push
    for (int k = 1; k <= 8; k++)
      vt.push_back(mk(0, 1, k, 0, 1, 1, 1, k, k, 0));
    vt.push_back(mk(0, 0, 32'h0, 0, 1, 1, 0, 32'h0, 8, 0));
    // back-pressure fill, hold, then drain
    vt.push_back(mk(0, 1, 32'hA5A5A5A5, 0, 0, 1, 1, 32'hA5A5A5A5, 9, 0));
    vt.push_back(mk(0, 1, 32'h5A5A5A5A, 0, 0, 1, 1, 32'hA5A5A5A5, 10, 0));
    vt.push_back(mk(0, 0, 32'h0, 0, 0, 0, 1, 32'hA5A5A5A5, 10, 0));
    vt.push_back(mk(0, 0, 32'h0, 0, 1, 0, 1, 32'h5A5A5A5A, 10, 0));
    vt.push_back(mk(0, 0, 32'h0, 0, 1, 1, 0, 32'h0, 10, 0));
    // fill, then flush while FULL with DEADBEEF offered and out_ready=1
    vt.push_back(mk(0, 1, 32'h11111111, 0, 0, 1, 1, 32'h11111111, 11, 0));
    vt.push_back(mk(0, 1, 32'h22222222, 0, 0, 1, 1, 32'h11111111, 12, 0));
    vt.push_back(mk(0, 1, 32'hDEADBEEF, 1, 1, 0, 0, 32'h0, 12, 2));
    // simultaneous push and pop in ONE
    vt.push_back(mk(0, 1, 32'h11, 0, 0, 1, 1, 32'h11, 13, 2));
    vt.push_back(mk(0, 1, 32'h22, 0, 1, 1, 1, 32'h22, 14, 2));
    vt.push_back(mk(0, 0, 32'h0, 0, 1, 1, 0, 32'h0, 14, 2));
    // flush from ONE, push in the very next cycle
    vt.push_back(mk(0, 1, 32'h33, 0, 0, 1, 1, 32'h33, 15, 2));
    vt.push_back(mk(0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 15, 3));
    vt.push_back(mk(0, 1, 32'h44, 0, 0, 1, 1, 32'h44, 16, 3));
    // reset while FULL
    vt.push_back(mk(0, 1, 32'h55, 0, 0, 1, 1, 32'h44, 17, 3));
    vt.push_back(mk(1, 1, 32'h66, 0, 0, 0, 0, 32'h0, 0, 0));
    vt.push_back(mk(0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 0, 0));

    // first edge clears the uninitialised state before checking starts
    step();
    mon_en = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      rst           = vt[i].rst;
      tb_in_valid   = vt[i].iv;
      tb_in_control = vt[i].din;
      tb_flush      = vt[i].fl;
      tb_out_ready  = vt[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), {31'b0, if16.in_ready}, {31'b0, vt[i].e_ir});
      step();
      chk($sformatf("v%0d_out_valid", i), {31'b0, if16.out_valid}, {31'b0, vt[i].e_ov});
      chk($sformatf("v%0d_out_control", i), if16.out_control, vt[i].e_oc);
      chk($sformatf("v%0d_accept16", i), {16'b0, if16.accept_count}, vt[i].e_acc & 32'hFFFF);
      chk($sformatf("v%0d_accept4", i), {28'b0, if4.accept_count}, vt[i].e_acc & 32'hF);
      chk($sformatf("v%0d_drop16", i), {16'b0, if16.drop_count}, vt[i].e_drop);
    end

    // counter bounds: 17 accepts, then 16 flushes each taken while ONE
    rst = 1'b1; tb_in_valid = 1'b0; tb_flush = 1'b0; tb_out_ready = 1'b0;
    step();
    rst = 1'b0;
    tb_in_valid = 1'b1;
    tb_out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      tb_in_control = 32'h100 + k;
      step();
    end
    tb_in_valid = 1'b0;
    tb_out_ready = 1'b0;
    chk("cnt_accept4_wrap", {28'b0, if4.accept_count}, 32'd1);
    chk("cnt_accept16", {16'b0, if16.accept_count}, 32'd17);
    chk("cnt_one_before_flush", {31'b0, if4.out_valid}, 32'd1);
    for (int f = 0; f < 16; f++) begin
      tb_flush = 1'b1;
      step();
      tb_flush = 1'b0;
      if (f < 15) begin
        tb_in_valid = 1'b1;
        tb_in_control = 32'h200 + f;
        step();
        tb_in_valid = 1'b0;
      end
    end
    chk("cnt_drop4_sat", {28'b0, if4.drop_count}, 32'd15);
    chk("cnt_drop16", {16'b0, if16.drop_count}, 32'd16);
    chk("cnt_accept4_final", {28'b0, if4.accept_count}, 32'd0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
